// File: rtl/hbe_pkg.sv
// Shared types and helpers for the highest-bit encoder: FSM state encoding
// and the index-width derivation used by the top and its priority encoder.
package hbe_pkg;

    typedef enum logic {
        HBE_IDLE = 1'b0,
        HBE_EMIT = 1'b1
    } hbe_state_e;

    function automatic int hbe_idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/msb_prio_enc.sv
// Purpose: combinational MSB-first priority encoder with any/multi flags.
// Latency: purely combinational, no registers.
// Backpressure: none; the caller owns all flow control.
module msb_prio_enc
    import hbe_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = hbe_idx_w(W)
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Ascending scan so the highest set bit is the final assignment.
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any   = |vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - W'(1)));

endmodule

// File: rtl/highest_bit_encoder.sv
// Purpose: stream the index of every set bit of a word, highest first (HBE_COUNT_EN adds out_cnt).
// Latency: first beat 1 cycle after load; one beat per cycle; next word loads on the last beat.
// Backpressure: out_ready low freezes pend and all outputs; in_ready only while idle or on an accepted last beat.
module highest_bit_encoder
    import hbe_pkg::*;
#(
    parameter int W     = 8,
    parameter int IDX_W = hbe_idx_w(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_last
`ifdef HBE_COUNT_EN
    ,
    output logic [IDX_W:0]   out_cnt
`endif
);

    hbe_state_e       state_q, state_d;
    logic [W-1:0]     pend_q, pend_d, pend_clr;
    logic [IDX_W-1:0] top_idx;
    logic             pend_any, pend_multi;
    logic             emit, load, beat;

    msb_prio_enc #(
        .W     (W),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec   (pend_q),
        .idx   (top_idx),
        .any   (pend_any),
        .multi (pend_multi)
    );

    assign emit      = (state_q == HBE_EMIT);
    assign out_valid = emit;
    assign out_idx   = top_idx;
    // pend is only empty in EMIT when the loaded word itself was zero.
    assign out_none  = emit && !pend_any;
    assign out_last  = emit && !pend_multi;
    assign in_ready  = !emit || (out_ready && out_last);
    assign load      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

    always_comb begin
        pend_clr          = pend_q;
        pend_clr[top_idx] = 1'b0;
        state_d           = state_q;
        pend_d            = pend_q;
        if (load) begin
            pend_d  = in_word;
            state_d = HBE_EMIT;
        end else if (beat) begin
            pend_d = pend_clr;
            if (out_last) begin
                state_d = HBE_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HBE_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef HBE_COUNT_EN
    logic [IDX_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (IDX_W+1)'(1);
        end else if (beat && !out_last) begin
            cnt_d = cnt_q + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_highest_bit_encoder.sv
// Randomized scoreboard bench for highest_bit_encoder (W=8 and W=16 instances).
module tb_highest_bit_encoder;

    typedef struct {
        int idx;
        bit none;
        bit last;
        int cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_idx;
    logic        out_none;
    logic        out_last;

    logic        iv16 = 1'b0;
    logic        ir16;
    logic [15:0] iw16 = '0;
    logic        ov16;
    logic        or16 = 1'b1;
    logic [3:0]  oi16;
    logic        on16;
    logic        ol16;

`ifdef HBE_COUNT_EN
    logic [3:0]  out_cnt;
    logic [4:0]  oc16;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   beats8 = 0;
    int   mode = 0;
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    highest_bit_encoder #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last)
`ifdef HBE_COUNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    highest_bit_encoder #(.W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_word   (iw16),
        .out_valid (ov16),
        .out_ready (or16),
        .out_idx   (oi16),
        .out_none  (on16),
        .out_last  (ol16)
`ifdef HBE_COUNT_EN
        ,
        .out_cnt   (oc16)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: scan the word from the top, one expected beat per set bit.
    function automatic void model(input logic [15:0] w, input int width, output exp_t r[$]);
        int   k;
        int   n;
        exp_t e;
        k = 0;
        n = 0;
        r = {};
        for (int i = 0; i < width; i++) k += int'(w[i]);
        if (k == 0) begin
            e = '{0, 1'b1, 1'b1, 1};
            r.push_back(e);
        end else begin
            for (int i = width - 1; i >= 0; i--) begin
                if (w[i]) begin
                    n++;
                    e = '{i, 1'b0, (n == k), n};
                    r.push_back(e);
                end
            end
        end
    endfunction

    task automatic tick(input logic v, input logic [7:0] w, output bit acc);
        exp_t r[$];
        @(negedge clk);
        in_valid = v;
        in_word  = w;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            model({8'h00, w}, 8, r);
            foreach (r[i]) q8.push_back(r[i]);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
    endtask

    task automatic send(input logic [7:0] w);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) tick(1'b1, w, a);
        if (!a) chk("load_timeout", 0, 1);
    endtask

    // Monitor for the W=8 instance: scoreboard pops plus stall stability.
    bit         prev_stall = 1'b0;
    logic [5:0] saved = '0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", int'({out_valid, out_idx, out_none, out_last}), int'(saved));
            end
            if (out_valid && out_ready) begin
                beats8++;
                if (q8.size() == 0) begin
                    chk("unexpected_beat_idx", int'(out_idx), -1);
                end else begin
                    e = q8.pop_front();
                    chk("beat_idx", int'(out_idx), e.idx);
                    chk("beat_none", int'(out_none), int'(e.none));
                    chk("beat_last", int'(out_last), int'(e.last));
`ifdef HBE_COUNT_EN
                    chk("beat_cnt", int'(out_cnt), e.cnt);
`endif
                end
            end
            prev_stall = out_valid && !out_ready;
            saved      = {out_valid, out_idx, out_none, out_last};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && ov16 && or16) begin
            if (q16.size() == 0) begin
                chk("unexpected_beat16_idx", int'(oi16), -1);
            end else begin
                e = q16.pop_front();
                chk("beat16_idx", int'(oi16), e.idx);
                chk("beat16_none", int'(on16), int'(e.none));
                chk("beat16_last", int'(ol16), int'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        int   b0;
        exp_t r[$];

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_none", int'(out_none), 0);
        chk("rst_out_last", int'(out_last), 0);
`ifdef HBE_COUNT_EN
        chk("rst_out_cnt", int'(out_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 8'hA4: three beats on consecutive cycles.
        mode = 0;
        send(8'hA4);
        b0 = beats8;
        idle(3);
        #3;
        chk("a4_consecutive_beats", beats8 - b0, 3);
        idle(1);

        // Zero word: a single beat, then idle.
        send(8'h00);
        idle(1);
        tick(1'b0, 8'h00, a);
        chk("zero_back_idle_in_ready", int'(in_ready), 1);
        chk("zero_back_idle_out_valid", int'(out_valid), 0);

        // 8'hFF with out_ready toggling.
        mode = 1;
        send(8'hFF);
        idle(20);
        mode = 0;
        idle(2);

        // Back-to-back 8'h81 then 8'h10.
        send(8'h81);
        b0 = beats8;
        tick(1'b1, 8'h10, a);
        chk("b2b_no_early_load", int'(a), 0);
        tick(1'b1, 8'h10, a);
        chk("b2b_load_on_last", int'(a), 1);
        tick(1'b0, 8'h00, a);
        #3;
        chk("b2b_consecutive_beats", beats8 - b0, 3);
        idle(3);

        // Reset mid-word after the idx 7 beat of 8'h88.
        send(8'h88);
        tick(1'b0, 8'h00, a);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_drop_count", q8.size(), 1);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_out_valid", int'(out_valid), 0);
        idle(5);

        // W=16 instance with 16'h8001.
        @(negedge clk);
        iv16 = 1'b1;
        iw16 = 16'h8001;
        #1;
        chk("w16_load", int'(ir16), 1);
        if (ir16) begin
            model(16'h8001, 16, r);
            foreach (r[i]) q16.push_back(r[i]);
        end
        @(negedge clk);
        iv16 = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized words, gaps and backpressure.
        mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] w;
            w = 8'($urandom);
            if ($urandom_range(0, 7) == 0) w = 8'h00;
            send(w);
            idle(int'($urandom_range(0, 2)));
        end

        mode = 0;
        for (int i = 0; i < 100 && q8.size() != 0; i++) idle(1);
        idle(2);
        chk("drain_q8", q8.size(), 0);
        chk("drain_q16", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
